// File: rtl/audiodac_fifo_mc_if.sv
// Host-write and modulator-read handshake bundle for audiodac_fifo_mc.
// master = host/modulator side, slave = the FIFO.
interface audiodac_fifo_mc_if #(
    parameter int DW  = 16,
    parameter int NCH = 2
);
    logic [DW-1:0]     fifo_i;
    logic              fifo_rdy_i;
    logic              fifo_ack_o;
    logic              frame_rd_i;
    logic [NCH*DW-1:0] frame_o;
    logic              frame_vld_o;

    modport master (
        output fifo_i, fifo_rdy_i, frame_rd_i,
        input  fifo_ack_o, frame_o, frame_vld_o
    );

    modport slave (
        input  fifo_i, fifo_rdy_i, frame_rd_i,
        output fifo_ack_o, frame_o, frame_vld_o
    );
endinterface

// File: rtl/audiodac_fifo_mc.sv
// Multi-channel frame FIFO between host writes and the delta-sigma datapath.
// Optional saturating underrun counter: define AUDIODAC_FIFO_UNDERRUN_CNT_EN.
module audiodac_fifo_mc #(
    parameter  int DW    = 16,
    parameter  int NCH   = 2,
    parameter  int DEPTH = 8,
    parameter  int THR   = 2,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic                clk_i,
    input  logic                rst_i,
    audiodac_fifo_mc_if.slave   bus,
    output logic                fifo_full_o,
    output logic                fifo_empty_o,
    output logic                fifo_almost_empty_o,
    output logic [AW:0]         fifo_level_o,
    output logic                underrun_o,
    input  logic                underrun_clr_i,
`ifdef AUDIODAC_FIFO_UNDERRUN_CNT_EN
    output logic [7:0]          underrun_cnt_o,
`endif
    input  logic                tst_fifo_loop_i
);
    localparam int CW = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int FW = NCH * DW;

    typedef logic [FW-1:0] frame_t;

    frame_t        mem_q [DEPTH];
    frame_t        wbuf_q, wbuf_d;
    frame_t        frame_q, frame_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   level_q, level_d;
    logic [CW-1:0] ch_wr_q, ch_wr_d;
    logic          ack_q, ack_d;
    logic          armed_q, armed_d;
    logic          vld_q, vld_d;
    logic          full_q, full_d;
    logic          empty_q, empty_d;
    logic          ae_q, ae_d;
    logic          underrun_q, underrun_d;
`ifdef AUDIODAC_FIFO_UNDERRUN_CNT_EN
    logic [7:0]    cnt_q, cnt_d;
`endif

    logic          accept, last_ch, commit, rd_ok, rd_under, mem_we;
    frame_t        mem_wdata, commit_frame;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        wbuf_d       = wbuf_q;
        frame_d      = frame_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        ch_wr_d      = ch_wr_q;
        level_d      = level_q;
        mem_we       = 1'b0;

        // armed: rdy has been observed low since the last ack (4-phase handshake)
        accept   = bus.fifo_rdy_i && !ack_q && !full_q && !tst_fifo_loop_i && armed_q;
        last_ch  = (ch_wr_q == CW'(NCH - 1));
        commit   = accept && last_ch;
        rd_ok    = bus.frame_rd_i && (level_q != '0);
        rd_under = bus.frame_rd_i && (level_q == '0);

        // Earlier channels wait in wbuf, so a held partial frame survives loop mode.
        commit_frame = wbuf_q;
        commit_frame[(NCH-1)*DW +: DW] = bus.fifo_i;
        mem_wdata    = commit_frame;

        ack_d   = accept;
        armed_d = accept ? 1'b0 : (!bus.fifo_rdy_i ? 1'b1 : armed_q);
        vld_d   = bus.frame_rd_i;

        if (accept) begin
            for (int c = 0; c < NCH; c++) begin
                if (ch_wr_q == CW'(c)) wbuf_d[c*DW +: DW] = bus.fifo_i;
            end
            ch_wr_d = last_ch ? '0 : ch_wr_q + 1'b1;
        end

        if (commit) begin
            mem_we   = 1'b1;
            wr_ptr_d = wr_ptr_q + 1'b1;
        end

        if (rd_ok) begin
            frame_d  = mem_q[rd_ptr_q];
            rd_ptr_d = rd_ptr_q + 1'b1;
            if (tst_fifo_loop_i) begin
                mem_we    = 1'b1;
                mem_wdata = mem_q[rd_ptr_q];
                wr_ptr_d  = wr_ptr_q + 1'b1;
            end
        end else if (rd_under) begin
            frame_d = '0;
        end

        // Loop mode blocks accepts, so commit and recirculation never collide.
        case ({commit, rd_ok && !tst_fifo_loop_i})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase

        full_d     = (level_d == (AW+1)'(DEPTH));
        empty_d    = (level_d == '0);
        ae_d       = (level_d <= (AW+1)'(THR));
        underrun_d = rd_under ? 1'b1 : (underrun_clr_i ? 1'b0 : underrun_q);

`ifdef AUDIODAC_FIFO_UNDERRUN_CNT_EN
        cnt_d = cnt_q;
        if (underrun_clr_i)                     cnt_d = '0;
        else if (rd_under && cnt_q != 8'hFF)    cnt_d = cnt_q + 1'b1;
`endif
    end

    // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wbuf_q     <= '0;
            frame_q    <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            ch_wr_q    <= '0;
            level_q    <= '0;
            ack_q      <= 1'b0;
            armed_q    <= 1'b1;
            vld_q      <= 1'b0;
            full_q     <= 1'b0;
            empty_q    <= 1'b1;
            ae_q       <= 1'b1;
            underrun_q <= 1'b0;
`ifdef AUDIODAC_FIFO_UNDERRUN_CNT_EN
            cnt_q      <= '0;
`endif
        end else begin
            wbuf_q     <= wbuf_d;
            frame_q    <= frame_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            ch_wr_q    <= ch_wr_d;
            level_q    <= level_d;
            ack_q      <= ack_d;
            armed_q    <= armed_d;
            vld_q      <= vld_d;
            full_q     <= full_d;
            empty_q    <= empty_d;
            ae_q       <= ae_d;
            underrun_q <= underrun_d;
`ifdef AUDIODAC_FIFO_UNDERRUN_CNT_EN
            cnt_q      <= cnt_d;
`endif
        end
    end

    // NOTE: the storage array has no reset; level gating ensures stale entries are never read.
    always_ff @(posedge clk_i) begin
        if (mem_we) mem_q[wr_ptr_q] <= mem_wdata;
    end

    assign bus.fifo_ack_o      = ack_q;
    assign bus.frame_o         = frame_q;
    assign bus.frame_vld_o     = vld_q;
    assign fifo_full_o         = full_q;
    assign fifo_empty_o        = empty_q;
    assign fifo_almost_empty_o = ae_q;
    assign fifo_level_o        = level_q;
    assign underrun_o          = underrun_q;
`ifdef AUDIODAC_FIFO_UNDERRUN_CNT_EN
    assign underrun_cnt_o      = cnt_q;
`endif
endmodule
